// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Sits behind the VGA timing generator. Turns (x, y) into read addresses for
//   a synchronous-read, double-buffered 8-bit grayscale framebuffer, delays the
//   sync/blank signals by the memory round-trip so they stay aligned with the
//   returned pixel, and registers the DAC-facing outputs.
//   Total latency input -> output is MEM_LAT+2 cycles for colour and syncs.
//
// Ports
//   vga_clk, rst_n          pixel clock, async active-low reset
//   x, y                    current column / line from the timing generator
//   h_sync, v_sync          active-low syncs from the timing generator
//   blank_b                 high inside the active display area
//   frame_sel               requested display buffer, latched at (0,0) only
//   mem_addr, mem_rd_en     framebuffer read request {buf, y[7:0], x[7:0]}
//   mem_rdata               framebuffer data, MEM_LAT cycles after the request
//   vga_r/g/b               grayscale pixel replicated on all three channels
//   vga_hs, vga_vs          aligned active-low syncs
//   vga_blank_n, vga_sync_n aligned blank and combined sync
//   frame_start             one-cycle pulse after (0,0) is sampled
module vga_pixel_fetch #(
   parameter int IMG_W   = 256,
   parameter int IMG_H   = 256,
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 17
) (
   input  logic              vga_clk,
   input  logic              rst_n,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              h_sync,
   input  logic              v_sync,
   input  logic              blank_b,
   input  logic              frame_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n,
   output logic              vga_sync_n,
   output logic              frame_start
);

   logic               at_origin;
   logic               in_img;
   logic               buf_sel;
   logic               buf_now;
   logic [MEM_LAT:0]   hs_pipe;
   logic [MEM_LAT:0]   vs_pipe;
   logic [MEM_LAT:0]   vld_pipe;
   logic [7:0]         pix_q;

   assign at_origin = (x == 10'd0) && (y == 10'd0);
   assign in_img    = blank_b && ({1'b0, x} < 11'(IMG_W)) && ({1'b0, y} < 11'(IMG_H));

   // Bypass so that pixel (0,0) already reads from the newly selected buffer.
   assign buf_now   = at_origin ? frame_sel : buf_sel;

   // Stage A: address generation and buffer latch.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_sel     <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         frame_start <= 1'b0;
      end else begin
         buf_sel     <= buf_now;
         mem_rd_en   <= in_img;
         frame_start <= at_origin;
         // Address holds outside the image so the RAM bus stays quiet.
         if (in_img)
            mem_addr <= ADDR_W'({buf_now, y[7:0], x[7:0]});
      end
   end

   // Timing delay line: stage 0 is concurrent with Stage A, stage MEM_LAT
   // lines up with mem_rdata.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_pipe  <= '1;
         vs_pipe  <= '1;
         vld_pipe <= '0;
      end else if (MEM_LAT == 0) begin
         hs_pipe  <= {(MEM_LAT+1){h_sync}};
         vs_pipe  <= {(MEM_LAT+1){v_sync}};
         vld_pipe <= {(MEM_LAT+1){in_img}};
      end else begin
         hs_pipe  <= {hs_pipe[MEM_LAT-1:0], h_sync};
         vs_pipe  <= {vs_pipe[MEM_LAT-1:0], v_sync};
         vld_pipe <= {vld_pipe[MEM_LAT-1:0], in_img};
      end
   end

   // Output stage: black whenever the aligned pixel is not an image pixel.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q       <= 8'd0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else begin
         pix_q       <= vld_pipe[MEM_LAT] ? mem_rdata : 8'd0;
         vga_hs      <= hs_pipe[MEM_LAT];
         vga_vs      <= vs_pipe[MEM_LAT];
         vga_blank_n <= vld_pipe[MEM_LAT];
      end
   end

   assign vga_r      = pix_q;
   assign vga_g      = pix_q;
   assign vga_b      = pix_q;
   assign vga_sync_n = vga_hs & vga_vs;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: u1 uses defaults (MEM_LAT=1), u2 uses IMG_W=128,
// MEM_LAT=4. Each driven cycle pushes expected address/output records that a
// negedge monitor pops at their due cycle; tasks add targeted inline checks.
module tb_vga_pixel_fetch;
   localparam int ML2 = 4;

   logic        vga_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  x = '0, y = '0;
   logic        h_sync = 1'b1, v_sync = 1'b1, blank_b = 1'b0, frame_sel = 1'b0;

   logic [16:0] addr1, addr2;
   logic        en1, en2, hs1, vs1, bn1, sn1, fs1, hs2, vs2, bn2, sn2, fs2;
   logic [7:0]  rd1, rd2, r1, g1, b1, r2, g2, b2;

   int total = 0, bad = 0, cyc = 0;

   always #5 vga_clk = ~vga_clk;
   always @(posedge vga_clk) cyc <= cyc + 1;

   // RAM models: data = addr[7:0] ^ addr[15:8], latency 1 and 4.
   logic [7:0]           rp1 = '0;
   logic [ML2-1:0][7:0]  rp2 = '0;
   always @(posedge vga_clk) begin
      rp1 <= addr1[7:0] ^ addr1[15:8];
      rp2 <= {rp2[ML2-2:0], addr2[7:0] ^ addr2[15:8]};
   end
   assign rd1 = rp1;
   assign rd2 = rp2[ML2-1];

   vga_pixel_fetch #(.MEM_LAT(1)) u1 (
      .vga_clk(vga_clk), .rst_n(rst_n), .x(x), .y(y), .h_sync(h_sync),
      .v_sync(v_sync), .blank_b(blank_b), .frame_sel(frame_sel),
      .mem_addr(addr1), .mem_rd_en(en1), .mem_rdata(rd1),
      .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
      .vga_blank_n(bn1), .vga_sync_n(sn1), .frame_start(fs1));

   vga_pixel_fetch #(.IMG_W(128), .MEM_LAT(ML2)) u2 (
      .vga_clk(vga_clk), .rst_n(rst_n), .x(x), .y(y), .h_sync(h_sync),
      .v_sync(v_sync), .blank_b(blank_b), .frame_sel(frame_sel),
      .mem_addr(addr2), .mem_rd_en(en2), .mem_rdata(rd2),
      .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2),
      .vga_blank_n(bn2), .vga_sync_n(sn2), .frame_start(fs2));

   typedef struct { int due; logic [7:0] px; logic hs; logic vs; logic bl; } out_t;
   typedef struct { int due; logic en; logic [16:0] addr; logic fs; } adr_t;
   out_t qo1[$], qo2[$];
   adr_t qa1[$], qa2[$];
   logic        tb_buf = 1'b0;
   logic [16:0] ha1 = '0, ha2 = '0;

   // Drive one pixel for one cycle and queue what both DUTs must produce.
   task automatic drive(input int px, input int py, input logic hs, input logic vs,
                        input logic bl, input logic fsel);
      logic org, in1, in2;
      out_t o;
      adr_t ad;
      x = 10'(px); y = 10'(py); h_sync = hs; v_sync = vs; blank_b = bl; frame_sel = fsel;
      org = (px == 0) && (py == 0);
      if (org) tb_buf = fsel;
      in1 = bl && (px < 256) && (py < 256);
      in2 = bl && (px < 128) && (py < 256);
      if (in1) ha1 = {tb_buf, y[7:0], x[7:0]};
      if (in2) ha2 = {tb_buf, y[7:0], x[7:0]};
      ad.due = cyc + 1; ad.fs = org;
      ad.en = in1; ad.addr = ha1; qa1.push_back(ad);
      ad.en = in2; ad.addr = ha2; qa2.push_back(ad);
      o.hs = hs; o.vs = vs;
      o.due = cyc + 3;       o.bl = in1; o.px = in1 ? (x[7:0] ^ y[7:0]) : 8'd0; qo1.push_back(o);
      o.due = cyc + 2 + ML2; o.bl = in2; o.px = in2 ? (x[7:0] ^ y[7:0]) : 8'd0; qo2.push_back(o);
      @(posedge vga_clk); #1;
   endtask

   // Scoreboard monitor.
   adr_t ea;
   out_t eo;
   always @(negedge vga_clk) begin
      while (qa1.size() > 0 && qa1[0].due <= cyc) begin
         ea = qa1.pop_front(); total++;
         if (ea.due != cyc || {en1, fs1, addr1} !== {ea.en, ea.fs, ea.addr}) begin
            bad++;
            $display("FAIL sb_addr_u1 cyc=%0d got en=%b fs=%b addr=%h want en=%b fs=%b addr=%h",
                     cyc, en1, fs1, addr1, ea.en, ea.fs, ea.addr);
         end
      end
      while (qa2.size() > 0 && qa2[0].due <= cyc) begin
         ea = qa2.pop_front(); total++;
         if (ea.due != cyc || {en2, fs2, addr2} !== {ea.en, ea.fs, ea.addr}) begin
            bad++;
            $display("FAIL sb_addr_u2 cyc=%0d got en=%b fs=%b addr=%h want en=%b fs=%b addr=%h",
                     cyc, en2, fs2, addr2, ea.en, ea.fs, ea.addr);
         end
      end
      while (qo1.size() > 0 && qo1[0].due <= cyc) begin
         eo = qo1.pop_front(); total++;
         if (eo.due != cyc || {r1, g1, b1, hs1, vs1, bn1, sn1} !==
             {eo.px, eo.px, eo.px, eo.hs, eo.vs, eo.bl, eo.hs & eo.vs}) begin
            bad++;
            $display("FAIL sb_out_u1 cyc=%0d got rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b want px=%h hs=%b vs=%b bn=%b",
                     cyc, r1, g1, b1, hs1, vs1, bn1, sn1, eo.px, eo.hs, eo.vs, eo.bl);
         end
      end
      while (qo2.size() > 0 && qo2[0].due <= cyc) begin
         eo = qo2.pop_front(); total++;
         if (eo.due != cyc || {r2, g2, b2, hs2, vs2, bn2, sn2} !==
             {eo.px, eo.px, eo.px, eo.hs, eo.vs, eo.bl, eo.hs & eo.vs}) begin
            bad++;
            $display("FAIL sb_out_u2 cyc=%0d got rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b want px=%h hs=%b vs=%b bn=%b",
                     cyc, r2, g2, b2, hs2, vs2, bn2, sn2, eo.px, eo.hs, eo.vs, eo.bl);
         end
      end
      if (bn1 === 1'b0) begin
         total++;
         if ({r1, g1, b1} !== 24'd0) begin
            bad++; $display("FAIL blank_black_u1 cyc=%0d got rgb=%h want 0", cyc, {r1, g1, b1});
         end
      end
   end

   localparam logic [48:0] RST_VAL = {1'b1, 1'b1, 1'b0, 1'b1, 24'd0, 1'b0, 1'b0, 17'd0};

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 1023));
         h_sync = 1'($urandom); v_sync = 1'($urandom);
         blank_b = 1'($urandom); frame_sel = 1'($urandom);
         @(negedge vga_clk);
         total++;
         if ({hs1, vs1, bn1, sn1, r1, g1, b1, en1, fs1, addr1} !== RST_VAL) begin
            bad++; $display("FAIL reset_u1 got %h want %h", {hs1, vs1, bn1, sn1, r1, g1, b1, en1, fs1, addr1}, RST_VAL);
         end
         total++;
         if ({hs2, vs2, bn2, sn2, r2, g2, b2, en2, fs2, addr2} !== RST_VAL) begin
            bad++; $display("FAIL reset_u2 got %h want %h", {hs2, vs2, bn2, sn2, r2, g2, b2, en2, fs2, addr2}, RST_VAL);
         end
         @(posedge vga_clk); #1;
      end
      rst_n = 1'b1; tb_buf = 1'b0; ha1 = '0; ha2 = '0;
   endtask

   task automatic test_addr_latency();
      for (int i = 0; i < 6; i++) drive(0, 300, 1, 1, 0, 0);
      drive(5, 3, 0, 0, 1, 0);
      @(negedge vga_clk);
      total++;
      if ({en1, addr1} !== {1'b1, 17'h00305}) begin
         bad++; $display("FAIL addr_u1 got en=%b addr=%h want en=1 addr=00305", en1, addr1);
      end
      total++;
      if ({en2, addr2} !== {1'b1, 17'h00305}) begin
         bad++; $display("FAIL addr_u2 got en=%b addr=%h want en=1 addr=00305", en2, addr2);
      end
      for (int k = 2; k <= 6; k++) begin
         drive(0, 300, 1, 1, 0, 0);
         @(negedge vga_clk);
         if (k == 2) begin
            total++;
            if ({r1, hs1} !== {8'h00, 1'b1}) begin
               bad++; $display("FAIL lat_early_u1 got r=%h hs=%b want r=00 hs=1", r1, hs1);
            end
         end
         if (k == 3) begin
            total++;
            if ({r1, g1, b1, hs1, vs1, bn1} !== {24'h060606, 1'b0, 1'b0, 1'b1}) begin
               bad++; $display("FAIL lat_u1 got rgb=%h%h%h hs=%b vs=%b bn=%b want 060606 0 0 1", r1, g1, b1, hs1, vs1, bn1);
            end
         end
         if (k == 5) begin
            total++;
            if ({r2, hs2, vs2} !== {8'h00, 1'b1, 1'b1}) begin
               bad++; $display("FAIL lat_early_u2 got r=%h hs=%b vs=%b want 00 1 1", r2, hs2, vs2);
            end
         end
         if (k == 6) begin
            total++;
            if ({r2, g2, b2, hs2, vs2, bn2} !== {24'h060606, 1'b0, 1'b0, 1'b1}) begin
               bad++; $display("FAIL lat_u2 got rgb=%h%h%h hs=%b vs=%b bn=%b want 060606 0 0 1", r2, g2, b2, hs2, vs2, bn2);
            end
         end
      end
   endtask

   task automatic test_sync_align();
      int c_in, c_out;
      logic prev_in, prev_out;
      c_in = -1; c_out = -1; prev_in = 1'b1; prev_out = 1'b1;
      for (int ly = 254; ly <= 256; ly++) begin
         for (int lx = 0; lx < 688; lx++) begin
            logic hs;
            hs = !(lx >= 656 && lx < 680);
            if (c_in < 0 && prev_in && !hs) c_in = cyc;
            prev_in = hs;
            drive(lx, ly, hs, ly != 256, lx < 640, 0);
            @(negedge vga_clk);
            if (c_out < 0 && prev_out && !hs1) c_out = cyc;
            prev_out = hs1;
         end
      end
      total++;
      if (c_out < 0 || c_in < 0 || c_out - c_in != 3) begin
         bad++; $display("FAIL hs_align got lag=%0d want 3", (c_out < 0) ? -1 : c_out - c_in);
      end
   endtask

   task automatic test_buf_swap();
      int pulses;
      pulses = 0;
      for (int f = 0; f < 3; f++) begin
         for (int ly = 0; ly < 110; ly++) begin
            for (int lx = 0; lx < 12; lx++) begin
               logic fsel;
               if (f == 0)      fsel = (ly >= 100);
               else if (f == 1) fsel = !(ly >= 50 && ly < 60);
               else             fsel = 1'b0;
               drive(lx, ly, lx != 11, ly < 108, lx < 10, fsel);
               @(negedge vga_clk);
               if (fs1 === 1'b1) pulses++;
               if (lx < 10) begin
                  total++;
                  if (addr1[16] !== (f == 1)) begin
                     bad++; $display("FAIL buf_bit f=%0d y=%0d x=%0d got %b want %b", f, ly, lx, addr1[16], f == 1);
                  end
               end
            end
         end
      end
      total++;
      if (pulses != 3) begin
         bad++; $display("FAIL frame_start_count got %0d want 3", pulses);
      end
   endtask

   task automatic test_out_of_image();
      drive(127, 10, 1, 1, 1, 0);
      drive(128, 10, 1, 1, 1, 0);
      drive(200, 10, 1, 1, 1, 0);
      @(negedge vga_clk);
      total++;
      if ({en1, en2, addr2} !== {1'b1, 1'b0, 17'h00A7F}) begin
         bad++; $display("FAIL oob_rd got en1=%b en2=%b addr2=%h want 1 0 00a7f", en1, en2, addr2);
      end
      for (int k = 2; k <= 6; k++) begin
         drive(0, 300, 1, 1, 0, 0);
         @(negedge vga_clk);
         if (k == 3) begin
            total++;
            if ({r1, bn1} !== {8'hC2, 1'b1}) begin
               bad++; $display("FAIL oob_u1_pix got r=%h bn=%b want c2 1", r1, bn1);
            end
         end
         if (k == 4) begin
            total++;
            if ({r2, bn2} !== {8'h75, 1'b1}) begin
               bad++; $display("FAIL edge_127_u2 got r=%h bn=%b want 75 1", r2, bn2);
            end
         end
         if (k == 6) begin
            total++;
            if ({r2, g2, b2, bn2} !== 25'd0) begin
               bad++; $display("FAIL oob_u2_pix got rgb=%h%h%h bn=%b want 0 0", r2, g2, b2, bn2);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         int px, py;
         px = $urandom_range(0, 300); py = $urandom_range(0, 300);
         if ($urandom_range(0, 15) == 0) begin px = 0; py = 0; end
         drive(px, py, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
      end
      for (int i = 0; i < 8; i++) drive(0, 300, 1, 1, 0, 0);
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) drive(20 + i, 7, 0, 0, 1, 1);
      #2;
      rst_n = 1'b0;
      qa1.delete(); qa2.delete(); qo1.delete(); qo2.delete();
      tb_buf = 1'b0; ha1 = '0; ha2 = '0;
      #1;
      total++;
      if ({hs1, vs1, bn1, sn1, r1, g1, b1, en1, fs1, addr1} !== RST_VAL) begin
         bad++; $display("FAIL midreset_u1 got %h want %h", {hs1, vs1, bn1, sn1, r1, g1, b1, en1, fs1, addr1}, RST_VAL);
      end
      total++;
      if ({hs2, vs2, bn2, sn2, r2, g2, b2, en2, fs2, addr2} !== RST_VAL) begin
         bad++; $display("FAIL midreset_u2 got %h want %h", {hs2, vs2, bn2, sn2, r2, g2, b2, en2, fs2, addr2}, RST_VAL);
      end
      @(posedge vga_clk); #1;
      rst_n = 1'b1;
      drive(9, 4, 1, 1, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge vga_clk);
         if (k == 2) begin
            total++;
            if ({r1, bn1} !== {8'h00, 1'b0}) begin
               bad++; $display("FAIL midreset_early got r=%h bn=%b want 00 0", r1, bn1);
            end
         end
         if (k == 3) begin
            total++;
            if ({r1, bn1} !== {8'h0D, 1'b1}) begin
               bad++; $display("FAIL midreset_first got r=%h bn=%b want 0d 1", r1, bn1);
            end
         end
         drive(0, 300, 1, 1, 0, 0);
      end
      for (int i = 0; i < 8; i++) drive(0, 300, 1, 1, 0, 0);
   endtask

   initial begin
      #1;
      test_reset();
      test_addr_latency();
      test_sync_align();
      test_buf_swap();
      test_out_of_image();
      test_back_to_back();
      test_mid_reset();
      @(negedge vga_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Downstream stage of the VGA timing generator. It consumes the generator's pixel coordinates and sync/blank signals and issues read addresses to a synchronous-read, double-buffered 8-bit grayscale framebuffer. It delays the timing signals by exactly the memory round-trip so they stay aligned, and drives the DAC-facing RGB/sync outputs. A frame-buffer select is latched only at frame start, so an image swap never tears mid-frame.

## Interface
Parameters:
- IMG_W, 256, image width in pixels (power of two, ≤ 256)
- IMG_H, 256, image height in lines (power of two, ≤ 256)
- MEM_LAT, 1, framebuffer read latency in cycles from registered address to valid data (legal 1..4)
- ADDR_W, 17, framebuffer address width = 1 buffer bit + 8 y bits + 8 x bits

Ports:
- vga_clk  in  1  pixel clock, shared with the timing generator
- rst_n  in  1  asynchronous active-low reset
- x  in  10  current column from the timing generator
- y  in  10  current line from the timing generator
- h_sync  in  1  active-low horizontal sync from the timing generator
- v_sync  in  1  active-low vertical sync from the timing generator
- blank_b  in  1  high inside the active area
- frame_sel  in  1  requested display buffer (0/1), sampled at frame start only
- mem_addr  out  ADDR_W  framebuffer read address {buf_sel, y[7:0], x[7:0]}
- mem_rd_en  out  1  read strobe, high for in-image active pixels
- mem_rdata  in  8  framebuffer data, valid MEM_LAT cycles after mem_addr/mem_rd_en
- vga_r, vga_g, vga_b  out  8 each  pixel colour (grayscale replicated)
- vga_hs, vga_vs  out  1 each  aligned active-low syncs
- vga_blank_n  out  1  aligned blank, high when displaying
- vga_sync_n  out  1  vga_hs & vga_vs
- frame_start  out  1  one-cycle pulse, registered, when (x,y) = (0,0) is sampled

## Operation
- Stage A (registered, 1 cycle): in_img = blank_b & (x < IMG_W) & (y < IMG_H). mem_rd_en <= in_img. mem_addr <= {buf_sel, y[7:0], x[7:0]} when in_img, otherwise held at its previous value.
- buf_sel register: loaded from frame_sel in the cycle where x==0 and y==0 are sampled; the same cycle's Stage A address already uses the new value, through a bypass mux. frame_sel changes at any other time have no effect until the next frame start.
- frame_start <= (x==0 && y==0).
- Stage B (memory): external RAM; data is valid MEM_LAT cycles after Stage A.
- Delay line: {h_sync, v_sync, in_img} are shifted through MEM_LAT+1 registers, so the tap aligns with mem_rdata.
- Output stage (registered): when the delayed in_img is 1, vga_r/g/b <= mem_rdata; otherwise 0. vga_hs/vga_vs take the delayed syncs. vga_blank_n takes the delayed in_img. vga_sync_n = vga_hs & vga_vs (combinational from the output registers).
- Active pixels outside the image (blank_b=1 but x ≥ IMG_W or y ≥ IMG_H) are forced black and get no read.
- No state machine beyond the pipeline. The block is free-running and has no back-pressure; the RAM must accept a read every cycle.

## Timing
- End-to-end latency from input sample to output = MEM_LAT+2 cycles for both colour and sync. With the default MEM_LAT=1 this is 3 cycles.
- mem_addr/mem_rd_en lag the inputs by 1 cycle.
- Reset (asynchronous assert, synchronous release): mem_addr=0, mem_rd_en=0, buf_sel=0, frame_start=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_sync_n=1. Every delay-line stage resets to hs=1, vs=1, in_img=0.
- Reset mid-line: outputs go to reset values immediately. The first valid pixel appears MEM_LAT+2 cycles after the first post-reset in-image sample.
- Wrap-around: x=255 → x=0 on a new line, and y wrap at VMAX, need no special handling, because the address is derived directly from x and y.
- Simultaneous frame_sel change and (0,0): the new value applies to pixel (0,0).

## Test plan
- Reset: hold rst_n=0 for 5 cycles with random inputs → vga_hs=vga_vs=1, vga_blank_n=0, RGB=0, mem_rd_en=0 throughout.
- Address/latency: RAM model returns mem_rdata = addr[7:0] ^ addr[15:8] with MEM_LAT=1; drive x=5, y=3, blank_b=1 → mem_addr=0x00305 one cycle later, and vga_r=g=b=0x06 exactly 3 cycles after the input.
- Sync alignment: drive a full timing sequence (HMAX=688) → the vga_hs falling edge lags the h_sync falling edge by exactly 3 cycles, and no RGB is non-zero while vga_blank_n=0.
- Buffer swap: set frame_sel=1 at line 100 → mem_addr[16] stays 0 until (0,0) of the next frame, then reads 1 for the whole frame. frame_start pulses once per frame.
- Out-of-image: IMG_W=128, x=200, blank_b=1 → mem_rd_en=0, RGB=0, vga_blank_n=0.
- Latency sweep: repeat the address test with MEM_LAT=4 → RGB and syncs both appear 6 cycles after the input.
